// File: rtl/nearest_hit_pkg.sv
// Shared types and constants for the nearest-hit selector that follows the
// fixed-point divider in the ray/triangle intersection path.
package nearest_hit_pkg;

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        EMIT  = 1'b1
    } state_t;

    localparam int unsigned D_WIDTH_DEF   = 32;
    localparam int unsigned IDX_WIDTH_DEF = 4;

    typedef struct packed {
        logic signed [D_WIDTH_DEF-1:0]   t;
        logic        [IDX_WIDTH_DEF-1:0] idx;
        logic                            hit;
    } hit_t;

    // Largest positive signed value of the given width: the divider's miss sentinel.
    function automatic logic [63:0] t_miss(input int unsigned width);
        t_miss = (64'd1 << (width - 32'd1)) - 64'd1;
    endfunction

endpackage

// File: rtl/t_compare.sv
// Classifies one divider result as a hit and compares it against the current best.
module t_compare
    import nearest_hit_pkg::*;
#(
    parameter int D_WIDTH = 32
) (
    input  logic signed [D_WIDTH-1:0] t,
    input  logic signed [D_WIDTH-1:0] best_t,
    output logic                      valid,
    output logic                      better
);

    localparam logic signed [D_WIDTH-1:0] T_MISS = D_WIDTH'(t_miss(D_WIDTH));
    localparam logic signed [D_WIDTH-1:0] T_ZERO = {D_WIDTH{1'b0}};

    // Signed hit test and strict less-than so ties keep the earlier triangle.
    always_comb begin
        valid  = 1'b0;
        better = 1'b0;
        if ((t > T_ZERO) && (t != T_MISS)) begin
            valid = 1'b1;
        end else begin
            valid = 1'b0;
        end
        if (t < best_t) begin
            better = 1'b1;
        end else begin
            better = 1'b0;
        end
    end

endmodule

// File: rtl/nearest_hit.sv
// Pops NUM_TRI hit distances per ray from the divider FIFO and writes the
// nearest valid one (with its triangle index) to the shading FIFO.
module nearest_hit
    import nearest_hit_pkg::*;
#(
    parameter int D_WIDTH   = 32,
    parameter int Q_BITS    = 10,
    parameter int NUM_TRI   = 16,
    parameter int IDX_WIDTH = $clog2(NUM_TRI)
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        in_empty,
    output logic                        in_rd_en,
    input  logic signed [D_WIDTH-1:0]   in_dout,
    input  logic                        out_full,
    output logic                        out_wr_en,
    output logic signed [D_WIDTH-1:0]   out_t,
    output logic        [IDX_WIDTH-1:0] out_idx,
    output logic                        out_hit
);

    localparam logic signed [D_WIDTH-1:0] T_MISS   = D_WIDTH'(t_miss(D_WIDTH));
    localparam logic [IDX_WIDTH-1:0]      LAST_IDX = IDX_WIDTH'(NUM_TRI - 1);
    localparam logic [IDX_WIDTH-1:0]      CNT_ONE  = IDX_WIDTH'(1);

    if ((NUM_TRI < 2) || (Q_BITS >= D_WIDTH)) begin : g_param_check
        $error("nearest_hit: NUM_TRI must be >= 2 and Q_BITS < D_WIDTH");
    end

    state_t                      state_r;
    logic        [IDX_WIDTH-1:0] cnt_r;
    logic signed [D_WIDTH-1:0]   best_t_r;
    logic        [IDX_WIDTH-1:0] best_idx_r;
    logic                        best_hit_r;

    logic                        valid_s;
    logic                        better_s;
    logic signed [D_WIDTH-1:0]   nxt_t_s;
    logic        [IDX_WIDTH-1:0] nxt_idx_s;
    logic                        nxt_hit_s;

    t_compare #(
        .D_WIDTH (D_WIDTH)
    ) u_t_compare (
        .t      (in_dout),
        .best_t (best_t_r),
        .valid  (valid_s),
        .better (better_s)
    );

    // FIFO strobes, held off while reset is asserted.
    always_comb begin
        in_rd_en  = 1'b0;
        out_wr_en = 1'b0;
        case (state_r)
            ACCUM:   in_rd_en  = reset & ~in_empty;
            EMIT:    out_wr_en = reset & ~out_full;
            default: begin
                in_rd_en  = 1'b0;
                out_wr_en = 1'b0;
            end
        endcase
    end

    // Running best including the value currently at the FIFO head.
    always_comb begin
        nxt_t_s   = best_t_r;
        nxt_idx_s = best_idx_r;
        nxt_hit_s = best_hit_r;
        if (valid_s && better_s) begin
            nxt_t_s   = in_dout;
            nxt_idx_s = cnt_r;
            nxt_hit_s = 1'b1;
        end else begin
            nxt_t_s   = best_t_r;
            nxt_idx_s = best_idx_r;
            nxt_hit_s = best_hit_r;
        end
    end

    // FSM, triangle counter, running best and registered result.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_r    <= ACCUM;
            cnt_r      <= {IDX_WIDTH{1'b0}};
            best_t_r   <= T_MISS;
            best_idx_r <= {IDX_WIDTH{1'b0}};
            best_hit_r <= 1'b0;
            out_t      <= {D_WIDTH{1'b0}};
            out_idx    <= {IDX_WIDTH{1'b0}};
            out_hit    <= 1'b0;
        end else begin
            case (state_r)
                ACCUM: begin
                    if (in_rd_en) begin
                        if (cnt_r == LAST_IDX) begin
                            out_t      <= nxt_t_s;
                            out_idx    <= nxt_idx_s;
                            out_hit    <= nxt_hit_s;
                            cnt_r      <= {IDX_WIDTH{1'b0}};
                            best_t_r   <= T_MISS;
                            best_idx_r <= {IDX_WIDTH{1'b0}};
                            best_hit_r <= 1'b0;
                            state_r    <= EMIT;
                        end else begin
                            cnt_r      <= cnt_r + CNT_ONE;
                            best_t_r   <= nxt_t_s;
                            best_idx_r <= nxt_idx_s;
                            best_hit_r <= nxt_hit_s;
                        end
                    end else begin
                        cnt_r <= cnt_r;
                    end
                end
                EMIT: begin
                    if (out_wr_en) begin
                        state_r <= ACCUM;
                    end else begin
                        state_r <= EMIT;
                    end
                end
                default: state_r <= ACCUM;
            endcase
        end
    end

endmodule

// File: doc/nearest_hit.md
# nearest_hit

Downstream consumer of the fixed-point divider (`divide_top`) in the ray/triangle intersection path. It pops per-triangle hit distances `t` from the divider's output FIFO, one ray's worth (`NUM_TRI` values, in triangle-index order) at a time. It keeps the smallest valid positive `t` and its triangle index, then writes one result per ray to a downstream FIFO for the shading stage.

## Interface
Parameters:
- `D_WIDTH`, 32, width of signed fixed-point `t`; must match the divider.
- `Q_BITS`, 10, fractional bits of `t`; 1.0 = 0x400. Carried for documentation and bench checks only; no arithmetic depends on it.
- `NUM_TRI`, 16, `t` values per ray; ≥2.
- `IDX_WIDTH`, `$clog2(NUM_TRI)`, triangle index width (derived).

Ports:
- `clock`  in  1  sole clock; all logic on posedge.
- `reset`  in  1  synchronous, active-low; sampled on posedge `clock`.
- `in_empty`  in  1  divider output FIFO empty.
- `in_rd_en`  out  1  pop from divider output FIFO.
- `in_dout`  in  `D_WIDTH`  signed `t`; first-word-fall-through, so valid whenever `!in_empty`.
- `out_full`  in  1  downstream FIFO full.
- `out_wr_en`  out  1  write result.
- `out_t`  out  `D_WIDTH`  nearest `t`, or `T_MISS` when there is no hit.
- `out_idx`  out  `IDX_WIDTH`  index of the nearest triangle; 0 when there is no hit.
- `out_hit`  out  1  at least one valid `t` in the ray.

## Operation
- **Valid hit:** `t > 0` and `t != T_MISS`. `T_MISS` = 0x7FFF_FFFF (max positive) is the divider's divide-by-zero/overflow sentinel. `t <= 0` and `T_MISS` are misses. The comparison is signed.
- **State machine:** `ACCUM` and `EMIT`.
- **`ACCUM` state:**
  - `in_rd_en = !in_empty`. Each pop compares `in_dout` against `best_t`.
  - On a valid hit with `in_dout < best_t` (strictly less), update `best_t`, `best_idx` to `cnt`, and set `best_hit` to 1.
  - Strict compare: on a tie, the lower index wins.
  - `cnt` increments per pop. The pop at `cnt == NUM_TRI-1` latches the final best, including that last value, into `out_t`/`out_idx`/`out_hit`. It also clears `cnt`, resets `best_t` to `T_MISS`, `best_idx` to 0 and `best_hit` to 0, and moves to `EMIT`.
- **`EMIT` state:**
  - `in_rd_en = 0`.
  - `out_wr_en = !out_full`.
  - When `out_wr_en` is 1, return to `ACCUM` next cycle.
  - `out_*` hold stable until the write occurs.
- No pops occur while in `EMIT`; the input FIFO absorbs backpressure.
- No arithmetic beyond the signed compare; widths are unchanged end to end.

## Timing
- **Reset** (`reset == 0` at posedge):
  - state = `ACCUM`, `cnt` = 0, `best_t` = `T_MISS`, `best_idx` = 0, `best_hit` = 0.
  - `out_t` = 0, `out_idx` = 0, `out_hit` = 0.
  - Any partial ray is discarded.
- `in_rd_en` and `out_wr_en` are combinational from state and flags. Both are forced to 0 while `reset == 0`.
- **Latency:** the result is available (`out_wr_en` = 1 if `!out_full`) in the cycle after the `NUM_TRI`-th pop.
- **Throughput:** `NUM_TRI` + 1 cycles per ray at best.
- `in_empty` bubbles stall `cnt` with no effect on the result.
- If `out_full` is held, the block stays in `EMIT` indefinitely with outputs frozen.
- `in_empty` is ignored in `EMIT`; `out_full` is ignored in `ACCUM`.
- **Reset mid-ray:** the next `NUM_TRI` pops after release form a fresh ray.

## Structure
- Package `nearest_hit_pkg`: `state_t` enum (`ACCUM`, `EMIT`), `T_MISS` constant as a function of `D_WIDTH`, and `hit_t` struct {`t`, `idx`, `hit`}.
- Sub-module `t_compare` (combinational): inputs `t`, `best_t`; outputs `valid` and `better`. Unit-testable on its own.
- `nearest_hit` is the FSM plus `cnt` and `best` registers, instantiating `t_compare`.

## Test plan
- **Basic minimum:** `NUM_TRI`=4; `t` = 0xC00, 0x400, 0x800, 0x1000 back-to-back → one write with `out_t`=0x400, `out_idx`=1, `out_hit`=1, in the cycle after the 4th pop.
- **All misses:** `t` = 0xFFFFFC00, 0x0, 0xFFFFF000, 0x7FFFFFFF → `out_hit`=0, `out_t`=0x7FFFFFFF, `out_idx`=0.
- **Tie:** `t` = 0x1000, 0xC00, 0x800, 0x800 → `out_idx`=2, `out_t`=0x800.
- **Backpressure:** `out_full`=1 for 5 cycles on entering `EMIT` → `out_wr_en`=0 and `in_rd_en`=0 throughout, outputs stable, exactly one write after release.
- **Input bubbles:** the basic-minimum values with `in_empty` toggled randomly between them → identical result; no pop while `in_empty`=1.
- **Reset mid-ray:** 2 pops, `reset`=0 for 1 cycle, then 0x800, 0x400, 0xFFFFFC00, 0xC00 → `out_t`=0x400, `out_idx`=1; all outputs read 0 in the cycle after reset.
